// File: rtl/uart_if.sv
// Transmit-side bundle shared by the UART TX core and its host/producer.
interface uart_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  sig;
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;

   modport tx   (input data, input valid, output sig, output ready);
   modport host (output data, output valid, input sig, input ready);
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: valid/ready word in, start + DATA_WIDTH LSB-first bits + stop out.
// Line level and ready are decoded from registered state, so they move on the handshake edge.
module uart_tx_core #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = 9600,
   parameter int CLK_FREQ   = 100_000_000
) (
   input  logic clk,
   input  logic rstn,
   uart_if.tx   txif
);
   localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
   localparam int CW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_WIDTH - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  tx_sig, tx_ready;
   logic                  bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      case (state_q)
         IDLE: begin
            if (txif.valid) begin
               shreg_d = txif.data;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               // index stops at the last bit instead of wrapping
               if (idx_q == IDX_LAST) state_d = STOP;
               else                   idx_d   = idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_sig   = 1'b1;
      tx_ready = 1'b0;
      case (state_q)
         IDLE:    tx_ready = 1'b1;
         START:   tx_sig   = 1'b0;
         DATA:    tx_sig   = shreg_q[idx_q];
         default: tx_sig   = 1'b1;
      endcase
   end

   assign txif.sig   = tx_sig;
   assign txif.ready = tx_ready;
endmodule

// File: tb/tb_uart_tx_core.sv
// Randomized bench for uart_tx_core: per-cycle line model plus mid-bit frame sampling.
module tb_uart_tx_core;
   localparam int DW    = 8;
   localparam int BAUD  = 100;
   localparam int CLKF  = 1000;
   localparam int PW    = CLKF / BAUD;
   localparam int FRAME = (DW + 2) * PW;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   uart_if #(.DATA_WIDTH(DW)) txif();

   uart_tx_core #(.DATA_WIDTH(DW), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF)) dut (
      .clk  (clk),
      .rstn (rstn),
      .txif (txif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Expected line level k bit-periods into a frame carrying w
   function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
      if (k == 0)       return 1'b0;
      else if (k <= DW) return w[k-1];
      else              return 1'b1;
   endfunction

   // Reference model: a frame lasts FRAME cycles from the accepting edge
   bit          m_act  = 1'b0;
   int          m_t    = 0;
   logic [DW-1:0] m_word = '0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_act <= 1'b0;
         m_t   <= 0;
      end else if (m_act) begin
         m_t <= m_t + 1;
         if (m_t + 1 == FRAME) m_act <= 1'b0;
      end else if (txif.valid === 1'b1) begin
         m_act  <= 1'b1;
         m_t    <= 0;
         m_word <= txif.data;
      end
   end

   always @(negedge clk) begin
      chk("line", txif.sig, m_act ? exp_bit(m_word, m_t / PW) : 1'b1);
      chk("ready", txif.ready, !m_act);
   end

   task automatic send(input logic [DW-1:0] w, input bit chg, input int abort_at);
      int lowcnt = 0;
      bit ok = 1'b0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         @(negedge clk);
         if (txif.ready === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      txif.data  = w;
      txif.valid = 1'b1;
      @(posedge clk);
      #1 txif.valid = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
         @(negedge clk);
         if (chg && c == 1) txif.data = ~w;
         if (c % PW == PW / 2) chk($sformatf("mid%0d", c / PW), txif.sig, exp_bit(w, c / PW));
         if (txif.ready === 1'b0) lowcnt++;
         if (c == abort_at) begin
            #2 rstn = 1'b0;
            #1;
            chk("rst_sig", txif.sig, 1'b1);
            chk("rst_ready", txif.ready, 1'b1);
            repeat (3) @(negedge clk);
            rstn = 1'b1;
            return;
         end
      end
      chk("ready_low_len", lowcnt, FRAME);
      @(negedge clk);
      chk("ready_back", txif.ready, 1'b1);
   endtask

   initial begin
      txif.valid = 1'b0;
      txif.data  = '0;
      repeat (100) begin
         @(negedge clk);
         chk("rst_hold_sig", txif.sig, 1'b1);
         chk("rst_hold_ready", txif.ready, 1'b1);
      end
      rstn = 1'b1;
      repeat (1000) @(negedge clk);

      send(8'h00, 1'b0, -1);
      send(8'hA5, 1'b0, -1);
      send(8'h3C, 1'b1, -1);
      for (int d = 0; d < 256; d++) send(DW'(d), 1'b0, -1);

      // data bit 3 occupies bit period 4
      send(8'h55, 1'b0, 4 * PW + PW / 2);
      send(8'h81, 1'b0, -1);

      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         send(DW'($urandom), 1'($urandom_range(0, 1)), -1);
      end

      // valid held high: words re-sent back to back, data wiggling mid-frame
      @(negedge clk);
      txif.data  = DW'($urandom);
      txif.valid = 1'b1;
      for (int i = 0; i < 3 * FRAME + 7; i++) begin
         @(negedge clk);
         if (i % 37 == 0) txif.data = DW'($urandom);
      end
      txif.valid = 1'b0;
      repeat (FRAME + 5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
